// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: funct3 width codes, FSM state
// encoding and the default memory depth.
package dmem_pkg;

   localparam int DMEM_DEPTH_DEFAULT = 256;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   // 011, 110 and 111 have no RV32I load/store meaning.
   function automatic logic is_legal_f3(input logic [2:0] f3);
      logic legal;
      case (f3)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: legal = 1'b1;
         default:                        legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory. Purely combinational:
// store side turns (funct3, offset, data) into byte enables and
// lane-replicated write data; load side extracts and extends the addressed
// byte/half from a full word. Offsets arrive already aligned by the caller.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_wd,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store: replicate narrow data across lanes so only the enables select.
   always_comb begin
      st_be    = 4'b0000;
      st_wdata = {4{st_wd[7:0]}};
      case (st_funct3)
         F3_B, F3_BU: st_be = 4'b0001 << st_off;
         F3_H, F3_HU: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_wd[15:0]}};
         end
         F3_W: begin
            st_be    = 4'b1111;
            st_wdata = st_wd;
         end
         default: st_be = 4'b0000;
      endcase
   end

   // Load: pick the addressed byte/half and extend per funct3.
   always_comb begin
      ld_byte = ld_word[7:0];
      case (ld_off)
         2'd0: ld_byte = ld_word[7:0];
         2'd1: ld_byte = ld_word[15:8];
         2'd2: ld_byte = ld_word[23:16];
         2'd3: ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ld_data = {16'd0, ld_half};
         F3_W:    ld_data = ld_word;
         default: ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable 32-bit data memory with a one-cycle request/response
// handshake. After reset it zeroes every word, one per cycle, before
// accepting requests.
// Build option: DMEM_MISALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses are rejected with err; otherwise they are silently aligned down.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clearing word clr_q this cycle; requests ignored
// ST_READY | accepting one request per cycle
module data_memory
   import dmem_pkg::*;
#(
   parameter int DEPTH = DMEM_DEPTH_DEFAULT,
   parameter int AW    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] memory_address,
   input  logic [31:0] WD2,
   output logic        rsp_valid,
   output logic [31:0] Data,
   output logic        err
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] clr_q, clr_d;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic [AW-1:0] idx;
   logic [1:0]    eff_off;
   logic          req_err;
   logic [3:0]    st_be;
   logic [31:0]   st_wdata;
   logic [31:0]   ld_data;
   logic          addr_unused;

   logic          rsp_valid_q;
   logic          rsp_err_q;
   logic          rsp_load_q;
   logic [2:0]    rsp_f3_q;
   logic [1:0]    rsp_off_q;
   logic [31:0]   rd_word_q;

   assign req_ready   = (state_q == ST_READY);
   assign accept      = req_valid && req_ready;
   assign idx         = memory_address[AW+1:2];
   assign addr_unused = ^memory_address[31:AW+2];

`ifdef DMEM_MISALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && memory_address[0])
                    || ((funct3 == F3_W) && (memory_address[1:0] != 2'b00));
   assign req_err    = !is_legal_f3(funct3) || misaligned;
   assign eff_off    = memory_address[1:0];
`else
   assign req_err = !is_legal_f3(funct3);
   // Misaligned halves/words are forced onto their natural boundary.
   always_comb begin
      eff_off = memory_address[1:0];
      if (funct3 == F3_W)
         eff_off = 2'b00;
      else if ((funct3 == F3_H) || (funct3 == F3_HU))
         eff_off = {memory_address[1], 1'b0};
   end
`endif

   dmem_lane_align u_lane_align (
      .st_funct3 (funct3),
      .st_off    (eff_off),
      .st_wd     (WD2),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_funct3 (rsp_f3_q),
      .ld_off    (rsp_off_q),
      .ld_word   (rd_word_q),
      .ld_data   (ld_data)
   );

   // State and clear-index register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_INIT;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   // Next state: walk the clear index across the whole array, then go ready.
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      case (state_q)
         ST_INIT: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == LAST_IDX) begin
               state_d = ST_READY;
               clr_d   = '0;
            end
         end
         ST_READY: state_d = ST_READY;
         default:  state_d = ST_INIT;
      endcase
   end

   // Storage: init clear or byte-lane store at the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == ST_INIT) begin
            mem[clr_q] <= '0;
         end else if (accept && MemWrite && !req_err) begin
            for (int i = 0; i < 4; i++) begin
               if (st_be[i])
                  mem[idx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
         end
      end
   end

   // Response pipeline: capture the raw word and decode info; extend next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_f3_q    <= 3'b000;
         rsp_off_q   <= 2'b00;
         rd_word_q   <= '0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_err_q  <= req_err;
            rsp_load_q <= !MemWrite;
            rsp_f3_q   <= funct3;
            rsp_off_q  <= eff_off;
            rd_word_q  <= mem[idx];
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign err       = rsp_valid_q && rsp_err_q;
   assign Data      = (rsp_valid_q && rsp_load_q && !rsp_err_q) ? ld_data : 32'd0;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] memory_address;
   logic [31:0] WD2;
   logic        rsp_valid;
   logic [31:0] Data;
   logic        err;

   int total = 0;
   int bad   = 0;

   // Reference memory: 1024 bytes, little-endian, byte address mod 1024.
   logic [7:0] mm [0:1023];

   data_memory dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .MemWrite       (MemWrite),
      .funct3         (funct3),
      .memory_address (memory_address),
      .WD2            (WD2),
      .rsp_valid      (rsp_valid),
      .Data           (Data),
      .err            (err)
   );

   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
   endfunction

   function automatic void model_req(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] d, output logic e);
      int a;
      int sz;
      bit sgn;
      logic [31:0] v;
      a = int'(addr[9:0]);
      sz = 0;
      sgn = 1'b0;
      d = 32'd0;
      e = 1'b0;
      case (f3)
         3'b000: begin sz = 1; sgn = 1'b1; end
         3'b001: begin sz = 2; sgn = 1'b1; end
         3'b010: sz = 4;
         3'b100: sz = 1;
         3'b101: sz = 2;
         default: sz = 0;
      endcase
      if (sz == 0) begin
         e = 1'b1;
         return;
      end
      if ((a % sz) != 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
         e = 1'b1;
         return;
`else
         a = a - (a % sz);
`endif
      end
      if (we) begin
         for (int i = 0; i < sz; i++) mm[a+i] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < sz; i++) v = v | (32'(mm[a+i]) << (8*i));
         if (sgn && sz < 4 && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
         d = v;
      end
   endfunction

   // One request (or idle cycle); response checked just after the edge.
   task automatic step(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] ed;
      logic        ee;
      ed = 32'd0;
      ee = 1'b0;
      check32("req_ready", {31'd0, req_ready}, 32'd1);
      req_valid = v; MemWrite = we; funct3 = f3; memory_address = a; WD2 = wd;
      if (v) model_req(we, f3, a, wd, ed, ee);
      @(posedge clk); #1;
      check32("rsp_valid", {31'd0, rsp_valid}, {31'd0, v});
      check32("Data", Data, ed);
      check32("err", {31'd0, err}, {31'd0, ee});
      req_valid = 1'b0;
   endtask

   // Reset for one edge, optionally with a load presented at that same edge.
   task automatic apply_reset(input logic with_load);
      reset = 1'b1;
      req_valid = with_load; MemWrite = 1'b0; funct3 = 3'b010;
      memory_address = 32'h0000_0020; WD2 = 32'd0;
      @(posedge clk); #1;
      check32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check32("rst_Data", Data, 32'd0);
      check32("rst_err", {31'd0, err}, 32'd0);
      check32("rst_req_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      req_valid = 1'b0;
   endtask

   // Count cycles until ready while hammering stores that must be ignored.
   task automatic wait_ready(input int exp_cycles);
      int n;
      bit saw_rsp;
      n = 0;
      saw_rsp = 1'b0;
      req_valid = 1'b1; MemWrite = 1'b1; funct3 = 3'b010;
      while (req_ready !== 1'b1 && n < 2000) begin
         memory_address = $urandom_range(0, 63);
         WD2 = $urandom;
         @(posedge clk); #1;
         if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
         n++;
      end
      req_valid = 1'b0;
      check32("init_cycles", n, exp_cycles);
      check32("init_no_rsp", {31'd0, saw_rsp}, 32'd0);
      model_clear();
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b0; req_valid = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
      memory_address = 32'd0; WD2 = 32'd0;
      model_clear();

      apply_reset(1'b0);
      wait_ready(256);

      step(1'b1, 1'b0, 3'b010, 32'h0000_03FC, 32'd0);
      check32("lw_3fc_after_init", Data, 32'h0000_0000);

      step(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0);
      check32("lb_13", Data, 32'hFFFF_FFDE);
      step(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'd0);
      check32("lbu_13", Data, 32'h0000_00DE);
      step(1'b1, 1'b0, 3'b001, 32'h0000_0012, 32'd0);
      check32("lh_12", Data, 32'hFFFF_DEAD);
      step(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0);
      check32("lhu_10", Data, 32'h0000_BEEF);

      step(1'b1, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_0055);
      step(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
      check32("sb_merge", Data, 32'hDEAD_55EF);

      step(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678);
      step(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
      check32("raw_next_cycle", Data, 32'h1234_5678);

      step(1'b0, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
      step(1'b1, 1'b0, 3'b010, 32'h0000_0022, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
      check32("lw_22_err", {31'd0, err}, 32'd1);
`else
      check32("lw_22_aligned", Data, 32'h1234_5678);
`endif
      step(1'b1, 1'b1, 3'b010, 32'h0000_0022, 32'hCAFE_F00D);
      step(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
`ifdef DMEM_MISALIGN_CHECK_EN
      check32("sw_22_no_write", Data, 32'h1234_5678);
`else
      check32("sw_22_aligned", Data, 32'hCAFE_F00D);
`endif
      step(1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'd0);
      check32("f3_011_load_err", {31'd0, err}, 32'd1);
      step(1'b1, 1'b1, 3'b111, 32'h0000_0020, 32'hFFFF_FFFF);
      check32("f3_111_store_err", {31'd0, err}, 32'd1);
      step(1'b1, 1'b0, 3'b010, 32'hFFFF_FC20, 32'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) a = $urandom;
         else a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), a, $urandom);
      end

      repeat (10) begin @(posedge clk); #1; end
      apply_reset(1'b0);
      repeat (10) begin @(posedge clk); #1; end
      check32("init_cycle10_not_ready", {31'd0, req_ready}, 32'd0);
      apply_reset(1'b0);
      wait_ready(256);

      step(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'hA5A5_5A5A);
      apply_reset(1'b1);
      wait_ready(256);
      step(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0);
      check32("cleared_after_reset", Data, 32'h0000_0000);

      for (int i = 0; i < 100; i++) begin
         a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
         step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
